// File: rtl/cla_nibble_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
// The producer drives operands and out_ready; the subtractor drives the rest.
interface cla_nibble_subtractor_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;
  logic         zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow, zero
  );
endinterface

// File: rtl/cla_nibble_subtractor.sv
// Nibble-serial A - B subtractor: one 4-bit borrow-lookahead slice is reused
// once per nibble, with the inter-nibble borrow held in a register.
module cla_nibble_subtractor #(
  parameter int NIBBLES = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  cla_nibble_subtractor_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_in_en;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_diff;
  logic [IDXW-1:0] r_idx;
  logic            r_borrow;
  logic            r_out_valid;
  logic            r_borrow_out;
  logic            r_overflow;
  logic            r_zero;

  logic            w_in_ready;
  logic            w_accept;
  logic            w_handoff;
  logic            w_last;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_bn;
  logic [4:0]      w_cla;
  logic            w_cout;
  logic [W-1:0]    w_diff_next;

  // 4-bit lookahead adder: all carries formed directly from P/G and cin.
  // Returns {cout, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] yn,
                                      input logic       cin);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;
    p    = x ^ yn;
    g    = x & yn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

  // in_ready is held low until the first edge with reset released.
  assign w_in_ready = (r_state == IDLE) && r_in_en;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_handoff  = r_out_valid && bus.out_ready;
  assign w_last     = (r_idx == LAST_IDX);

  // Current nibble: A_k + ~B_k + ~borrow (borrow is cleared at acceptance).
  assign w_nib_a  = r_a[{r_idx, 2'b00} +: 4];
  assign w_nib_bn = ~r_b[{r_idx, 2'b00} +: 4];
  assign w_cla    = cla4(w_nib_a, w_nib_bn, ~r_borrow);
  assign w_cout   = w_cla[4];

  // Result word with the current nibble merged in, so flags see the final value.
  always_comb begin
    w_diff_next = r_diff;
    w_diff_next[{r_idx, 2'b00} +: 4] = w_cla[3:0];
  end

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (w_handoff) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // State register and ready-enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_in_en <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_in_en <= 1'b1;
    end
  end

  // Operand capture, nibble iteration, result and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff       <= '0;
      r_idx        <= '0;
      r_borrow     <= 1'b0;
      r_out_valid  <= 1'b0;
      r_borrow_out <= 1'b0;
      r_overflow   <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= 1'b0;
            r_idx    <= '0;
          end
        end
        RUN: begin
          r_diff   <= w_diff_next;
          r_borrow <= ~w_cout;
          if (w_last) begin
            r_borrow_out <= ~w_cout;
            r_overflow   <= (r_a[W-1] ^ r_b[W-1]) & (w_diff_next[W-1] ^ r_a[W-1]);
            r_zero       <= (w_diff_next == '0);
            r_out_valid  <= 1'b1;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        DONE: begin
          if (w_handoff) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
  assign bus.overflow   = r_overflow;
  assign bus.zero       = r_zero;
endmodule
